// File: rtl/rr_arb_64b.sv
// rr_arb_64b: round-robin arbiter for up to 64 requesters.
// Lowest-index search is hierarchical (8 groups of 8). A rotating pointer masks
// the search for fairness. The grant is registered and one-hot, and it is held
// until done_i arrives, the owner drops its request, or the optional MAX_HOLD
// limit expires.
module rr_arb_64b #(
    parameter int unsigned MAX_HOLD = 256
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        en_i,
    input  logic [63:0] req_i,
    input  logic        done_i,
    output logic [63:0] gnt_o,
    output logic        gnt_vld_o,
    output logic [5:0]  gnt_id_o,
    output logic        timeout_o
);

    typedef enum logic [0:0] {StIdle, StGrant} state_e;

    // Last hcnt value of an allowed grant; unused when MAX_HOLD is 0.
    localparam logic [15:0] HoldLast = (MAX_HOLD == 0) ? 16'd0 : 16'(MAX_HOLD - 1);
    localparam logic        HoldOn   = (MAX_HOLD != 0);

    state_e      state_q;
    logic [5:0]  ptr_q;
    logic [15:0] hcnt_q;
    logic [63:0] gnt_q;
    logic [5:0]  gnt_id_q;
    logic        gnt_vld_q;
    logic        timeout_q;

    logic [63:0] mask;
    logic [6:0]  m_res;
    logic [6:0]  r_res;
    logic [5:0]  win;
    logic        owner_req;
    logic        hold_hit;
    logic        release_c;
    logic        limit_only;

    // Lowest set index of v: returns {found, group[2:0], bit[2:0]}.
    function automatic logic [6:0] lowest(input logic [63:0] v);
        logic [7:0]      grp_any;
        logic [7:0][2:0] grp_idx;
        logic [2:0]      gsel;
        for (int g = 0; g < 8; g++) begin
            grp_any[g] = |v[g*8 +: 8];
            grp_idx[g] = 3'd0;
            for (int b = 7; b >= 0; b--) begin
                if (v[g*8 + b]) grp_idx[g] = 3'(b);
            end
        end
        gsel = 3'd0;
        for (int g = 7; g >= 0; g--) begin
            if (grp_any[g]) gsel = 3'(g);
        end
        return {|grp_any, gsel, grp_idx[gsel]};
    endfunction

    // Winner selection and release decode.
    always_comb begin
        mask       = 64'hFFFF_FFFF_FFFF_FFFF << ptr_q;
        m_res      = lowest(req_i & mask);
        r_res      = lowest(req_i);
        // Fall back to the unmasked search when nothing sits at or above ptr.
        win        = m_res[6] ? m_res[5:0] : r_res[5:0];
        owner_req  = req_i[gnt_id_q];
        hold_hit   = HoldOn && (hcnt_q == HoldLast);
        release_c  = done_i || !owner_req || hold_hit;
        limit_only = hold_hit && !done_i && owner_req;
    end

    // Arbitration FSM with registered outputs.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q   <= StIdle;
            ptr_q     <= 6'd0;
            hcnt_q    <= 16'd0;
            gnt_q     <= 64'd0;
            gnt_id_q  <= 6'd0;
            gnt_vld_q <= 1'b0;
            timeout_q <= 1'b0;
        end else begin
            timeout_q <= 1'b0;
            unique case (state_q)
                StIdle: begin
                    if (en_i && |req_i) begin
                        gnt_q     <= 64'd1 << win;
                        gnt_id_q  <= win;
                        gnt_vld_q <= 1'b1;
                        ptr_q     <= win + 6'd1;  // wraps 63 -> 0
                        hcnt_q    <= 16'd0;
                        state_q   <= StGrant;
                    end
                end
                StGrant: begin
                    if (hcnt_q != 16'hFFFF) hcnt_q <= hcnt_q + 16'd1;
                    if (release_c) begin
                        gnt_q     <= 64'd0;
                        gnt_vld_q <= 1'b0;
                        timeout_q <= limit_only;
                        state_q   <= StIdle;
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    assign gnt_o     = gnt_q;
    assign gnt_vld_o = gnt_vld_q;
    assign gnt_id_o  = gnt_id_q;
    assign timeout_o = timeout_q;

endmodule

// File: doc/rr_arb_64b.md
# rr_arb_64b

Round-robin arbiter that shares one resource among up to 64 requesters. Winner selection uses the same hierarchical lowest-index priority resolution as the 64-bit priority encoder: 8 groups of 8 bits, one group-select level and eight in-group resolvers. A rotating pointer masks the search so the arbiter is fair. It has a registered one-hot grant, a release handshake and an optional hold-time limit. It sits between requesting engines and a shared datapath or bus port.

## Interface
- MAX_HOLD, default 256: maximum grant duration in cycles, range 0..65535. 0 disables the limit.
- clk_i  in  1  clock; all logic is rising-edge.
- rst_i  in  1  reset, asynchronous, active-high.
- en_i  in  1  arbitration enable. Low blocks new grants only; a grant in progress continues.
- req_i  in  64  request vector; bit k belongs to requester k.
- done_i  in  1  the current owner has finished. Sampled only in GRANT.
- gnt_o  out  64  one-hot grant; all zeros when idle.
- gnt_vld_o  out  1  a grant is active; equals |gnt_o.
- gnt_id_o  out  6  index of the current owner; holds its last value when idle.
- timeout_o  out  1  one-cycle pulse when a grant was revoked by MAX_HOLD.

## Operation
- Internal state:
  - FSM with two states, IDLE and GRANT.
  - 6-bit round-robin pointer ptr.
  - 16-bit hold counter hcnt.
- Winner selection (combinational on req_i and ptr):
  - Masked vector m = req_i with bits below ptr cleared.
  - If m is non-zero, the winner w is the lowest set index of m.
  - Otherwise w is the lowest set index of req_i.
- IDLE:
  - gnt_o = 0.
  - If en_i && |req_i at a rising edge: gnt_o <= 1<<w, gnt_id_o <= w, gnt_vld_o <= 1, ptr <= (w+1) mod 64, hcnt <= 0, go to GRANT.
  - ptr wraps from 63 to 0.
- GRANT:
  - hcnt increments each cycle, saturating at 65535.
  - Release condition R = done_i OR !req_i[gnt_id_o] OR (MAX_HOLD != 0 AND hcnt == MAX_HOLD-1).
  - On R at a rising edge: gnt_o <= 0, gnt_vld_o <= 0, go to IDLE.
  - timeout_o <= 1 only when the limit term is the sole true term of R. done_i or a dropped request on the same edge wins, and timeout_o stays 0.
- Changes to req_i bits other than the owner's have no effect during GRANT.
- en_i is ignored in GRANT.

## Timing
- Reset values:
  - Outputs: gnt_o = 0, gnt_vld_o = 0, gnt_id_o = 0, timeout_o = 0.
  - Internal: ptr = 0, hcnt = 0, state IDLE.
  - Reset is asynchronous and takes effect mid-grant without waiting for a clock edge.
  - First arbitration happens on the first rising edge after rst_i deasserts.
- Request to grant: 1 cycle. A request sampled at edge E gives gnt_o high after E.
- Release to gnt_o low: 1 cycle. done_i sampled at edge E gives gnt_o low after E.
- Back-to-back grants are separated by exactly 1 idle cycle, which is the turnaround guarantee for the shared resource.
- With MAX_HOLD = N > 0 and no other release cause, gnt_vld_o is high exactly N cycles. timeout_o is high the cycle after the last grant cycle, coincident with the idle cycle.
- gnt_o is always one-hot or zero. The bench asserts this every cycle.

## Test plan
- Async reset mid-grant:
  - Stimulus: req_i = 1<<7, granted; assert rst_i between clock edges.
  - Required: gnt_o = 0, gnt_vld_o = 0, gnt_id_o = 0 immediately. After release, req_i = 1<<2 and 1<<7 give a grant to 2 first, since ptr = 0.
- Single requester:
  - Stimulus: req_i = 1<<5 held; done_i pulses in the 3rd grant cycle.
  - Required: gnt_id_o = 5 one cycle after the request; grant lasts 3 cycles; 1 idle cycle; grant to 5 again.
- Full rotation:
  - Stimulus: req_i = all ones; done_i = 1 in every grant cycle.
  - Required: grant sequence 0,1,2,...,63,0,1, with alternating 1-cycle grant and 1-cycle idle.
- Wrap-around:
  - Stimulus: req_i = bits 3 and 60; ptr = 0.
  - Required: grants 3, 60, 3, 60. After 60, ptr = 61, m = 0, fallback picks 3.
- Timeout with MAX_HOLD = 4:
  - Stimulus: req_i = 1<<10 held, done_i = 0.
  - Required: gnt_vld_o high 4 cycles; timeout_o pulses once; 1 idle cycle; regrant to 10.
  - Stimulus: repeat with done_i = 1 in the 4th grant cycle.
  - Required: timeout_o = 0.
- Enable and request drop:
  - Stimulus: en_i = 0 with req_i non-zero.
  - Required: no grant.
  - Stimulus: en_i falls during a grant.
  - Required: the grant continues until done_i.
  - Stimulus: the owner's req bit drops.
  - Required: gnt_o = 0 the next cycle, timeout_o = 0.
